// File: rtl/mem_port_arbiter.sv
// Purpose : shares one memory port between instruction fetch and data load/store;
//           data beats fetch, write beats read when both d_read and d_write are high.
// Latency : done pulses 2 cycles after a request is seen in IDLE, +1 per mem_ready=0 cycle.
// Backpr. : requests are held until done; stall holds PC/regfile while an access is pending.
// Ports   : clock/Reset (async, active-high); fetch side if_req/if_addr -> if_rdata/if_done;
//           data side d_read/d_write/d_addr/d_wdata -> d_rdata/d_done; stall;
//           memory side mem_valid/mem_we/mem_addr/mem_wdata <- mem_ready/mem_rdata; mem_err.
// Config  : define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES wait cycles,
//           returning ERR_DATA and setting the sticky mem_err flag.
module mem_port_arbiter #(
   parameter int                ADDR_W         = 32,
   parameter int                DATA_W         = 32,
   parameter int                TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] ERR_DATA       = 32'h00000013
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic              stall,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_WAIT = 2'd1,
      D_WAIT  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              d_req;
   logic              d_ok;
   logic              if_ok;
   logic              in_wait;
   logic              timeout_hit;
   logic              xfer_end;
   logic [DATA_W-1:0] rdata_cap;

   // Decode and combinational outputs. A requester whose done is high this
   // cycle is locked out so its still-asserted level request is not re-granted.
   always_comb begin
      d_req     = d_read | d_write;
      d_ok      = d_req & ~d_done;
      if_ok     = if_req & ~if_done;
      in_wait   = (state != IDLE);
      xfer_end  = in_wait & (mem_ready | timeout_hit);
      // Only a timeout can end a transfer without mem_ready.
      rdata_cap = mem_ready ? mem_rdata : ERR_DATA;
      stall     = (if_req & ~if_done) | (d_req & ~d_done);
   end

   // State register
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (d_ok)       state_nxt = D_WAIT;
            else if (if_ok) state_nxt = IF_WAIT;
         end
         IF_WAIT, D_WAIT: begin
            if (xfer_end) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Registered memory request, captured read data and done pulses.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (d_ok) begin
                  mem_valid <= 1'b1;
                  mem_we    <= d_write;  // write wins over a simultaneous read
                  mem_addr  <= d_addr;
                  mem_wdata <= d_wdata;
               end else if (if_ok) begin
                  mem_valid <= 1'b1;
                  mem_we    <= 1'b0;
                  mem_addr  <= if_addr;
               end
            end
            IF_WAIT: begin
               if (xfer_end) begin
                  mem_valid <= 1'b0;
                  if_done   <= 1'b1;
                  if_rdata  <= rdata_cap;
               end
            end
            D_WAIT: begin
               if (xfer_end) begin
                  mem_valid <= 1'b0;
                  d_done    <= 1'b1;
                  if (!mem_we) d_rdata <= rdata_cap;
               end
            end
            default: mem_valid <= 1'b0;
         endcase
      end
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] wait_cnt;

   assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES));

   // Counter is held at zero in IDLE, so it always starts from zero on entering a WAIT state.
   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         wait_cnt <= '0;
         mem_err  <= 1'b0;
      end else begin
         if (!in_wait)                        wait_cnt <= '0;
         else if (!mem_ready && !timeout_hit) wait_cnt <= wait_cnt + 1'b1;
         if (in_wait && timeout_hit && !mem_ready) mem_err <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int TO = 4;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } trans_t;

   logic        clock = 1'b0;
   logic        Reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        stall;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        mem_err;

   mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .ERR_DATA(32'h00000013)
   ) dut (
      .clock(clock), .Reset(Reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .stall(stall),
      .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_err(mem_err)
   );

   always #5 clock = ~clock;

   int          n_chk = 0;
   int          n_fail = 0;
   int          if_done_cnt = 0;
   int          d_done_cnt = 0;
   bit          chk_timing = 1'b1;
   logic        exp_err = 1'b0;
   int          rdy_mode = 1;   // 0 random (<=2 waits), 1 always, 2 never, 3 after rdy_n waits
   int          rdy_n = 0;
   int          wcnt = 0;
   logic [31:0] exp_if_rdata = '0;
   logic [31:0] exp_d_rdata = '0;
   logic [31:0] env_mem [256];  // memory seen by the DUT
   logic [31:0] ref_mem [256];  // expected memory contents
   trans_t      trans_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Memory model: decides mem_ready for the current cycle and serves read data.
   task automatic respond();
      if (mem_valid) begin
         case (rdy_mode)
            0:       mem_ready = (wcnt >= 2) || ($urandom_range(0, 1) == 1);
            1:       mem_ready = 1'b1;
            2:       mem_ready = 1'b0;
            default: mem_ready = (wcnt >= rdy_n);
         endcase
         mem_rdata = env_mem[mem_addr[9:2]];
         if (mem_ready) begin
            if (mem_we) env_mem[mem_addr[9:2]] = mem_wdata;
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end else begin
         mem_ready = ($urandom_range(0, 1) == 1);
         mem_rdata = $urandom;
         wcnt = 0;
      end
   endtask

   // One clock cycle with monitor checks, sampled 1 time unit after the edge.
   task automatic cyc();
      logic        pv, pr, pwe;
      logic [31:0] pa, pw;
      trans_t      t;
      pv = mem_valid; pr = mem_ready; pwe = mem_we; pa = mem_addr; pw = mem_wdata;
      @(posedge clock);
      #1;
      if (chk_timing) chk1("done_timing", if_done | d_done, pv & pr);
      if (chk_timing && pv && !pr) begin
         chk1("hold_valid", mem_valid, 1'b1);
         chk("hold_addr", mem_addr, pa);
         chk1("hold_we", mem_we, pwe);
         if (pwe) chk("hold_wdata", mem_wdata, pw);
      end
      if (pv && pr) chk1("valid_drop", mem_valid, 1'b0);
      if (mem_valid && !(pv && !pr)) begin
         t.we = mem_we; t.addr = mem_addr; t.wdata = mem_wdata;
         trans_q.push_back(t);
      end
      if (if_done) if_done_cnt++;
      if (d_done)  d_done_cnt++;
      chk1("stall", stall, (if_req & ~if_done) | ((d_read | d_write) & ~d_done));
      chk1("mem_err", mem_err, exp_err);
      respond();
   endtask

   // One datapath operation: requests held until done, then checked against the model.
   task automatic do_op(input bit f, input bit rd, input bit wr,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                        output int if_at, output int d_at);
      bit          dreq;
      logic [31:0] exp_if, exp_d;
      int          n;
      trans_t      t;
      dreq = rd | wr;
      trans_q.delete();
      if_done_cnt = 0; d_done_cnt = 0; if_at = -1; d_at = -1;
      // Data is served before fetch, so a fetch aliasing a store sees the new value.
      exp_d = exp_d_rdata;
      if (dreq) begin
         if (wr) ref_mem[da[9:2]] = wd;
         else    exp_d = ref_mem[da[9:2]];
      end
      exp_if = ref_mem[ia[9:2]];
      if_req = f; if_addr = ia; d_read = rd; d_write = wr; d_addr = da; d_wdata = wd;
      n = 0;
      while ((if_req || d_read || d_write) && n < 60) begin
         cyc();
         n++;
         if (if_done) begin if_at = n; if_req = 1'b0; exp_if_rdata = exp_if; end
         if (d_done)  begin d_at = n; d_read = 1'b0; d_write = 1'b0; exp_d_rdata = exp_d; end
      end
      chk1("op_budget", if_req | d_read | d_write, 1'b0);
      if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      repeat (2) cyc();
      chk("if_done_cnt", if_done_cnt, 32'(f));
      chk("d_done_cnt", d_done_cnt, 32'(dreq));
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("d_rdata", d_rdata, exp_d_rdata);
      chk("n_trans", trans_q.size(), 32'(f) + 32'(dreq));
      if (dreq && trans_q.size() > 0) begin
         t = trans_q.pop_front();
         chk1("d_we", t.we, wr);
         chk("d_addr", t.addr, da);
         if (wr) chk("d_wdata", t.wdata, wd);
      end
      if (f && trans_q.size() > 0) begin
         t = trans_q.pop_front();
         chk1("if_we", t.we, 1'b0);
         chk("if_addr", t.addr, ia);
      end
   endtask

   initial begin
      int          ia_at, d_at;
      logic [31:0] v;
      for (int i = 0; i < 256; i++) begin
         v = $urandom;
         env_mem[i] = v;
         ref_mem[i] = v;
      end
      env_mem[0] = 32'h00500093;
      ref_mem[0] = 32'h00500093;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk1("rst_mem_valid", mem_valid, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_if_rdata", if_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      chk1("rst_if_done", if_done, 1'b0);
      chk1("rst_d_done", d_done, 1'b0);
      chk1("rst_mem_err", mem_err, 1'b0);
      chk1("rst_stall", stall, 1'b0);
      Reset = 1'b0;

      // Fetch only, zero-wait memory
      rdy_mode = 1;
      do_op(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, ia_at, d_at);
      chk("t1_if_lat", ia_at, 2);
      chk("t1_if_rdata", if_rdata, 32'h00500093);

      // Fetch and load together: data first, fetch granted in the d_done cycle
      do_op(1'b1, 1'b1, 1'b0, 32'h4, 32'h100, 32'h0, ia_at, d_at);
      chk("t2_d_lat", d_at, 2);
      chk("t2_if_lat", ia_at, 4);

      // Store with 3 wait cycles, then read it back
      rdy_mode = 3; rdy_n = 3;
      do_op(1'b0, 1'b0, 1'b1, 32'h0, 32'h20, 32'hDEADBEEF, ia_at, d_at);
      chk("t3_d_lat", d_at, 5);
      rdy_mode = 1;
      do_op(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, ia_at, d_at);
      chk("t3_readback", d_rdata, 32'hDEADBEEF);

      // Asynchronous reset in the middle of a fetch wait
      rdy_mode = 2; chk_timing = 1'b0;
      if_req = 1'b1; if_addr = 32'h8;
      cyc(); cyc();
      chk1("t4_valid_before", mem_valid, 1'b1);
      #3 Reset = 1'b1;
      #1;
      chk1("t4_valid_async", mem_valid, 1'b0);
      chk("t4_addr_async", mem_addr, 32'h0);
      chk("t4_if_rdata_async", if_rdata, 32'h0);
      chk("t4_d_rdata_async", d_rdata, 32'h0);
      if_req = 1'b0;
      exp_if_rdata = '0; exp_d_rdata = '0;
      @(posedge clock);
      #2 Reset = 1'b0;
      if_done_cnt = 0;
      repeat (4) cyc();
      chk("t4_no_if_done", if_done_cnt, 0);
      chk1("t4_idle_valid", mem_valid, 1'b0);
      rdy_mode = 1; chk_timing = 1'b1;

      // Read and write together: one write transaction
      do_op(1'b0, 1'b1, 1'b1, 32'h0, 32'h44, 32'h12345678, ia_at, d_at);
      chk("t5_d_lat", d_at, 2);
      chk("t5_d_rdata_kept", d_rdata, 32'h0);

`ifdef MEM_TIMEOUT_EN
      // Fetch with memory never ready: aborted after TO wait cycles
      rdy_mode = 2; chk_timing = 1'b0;
      if_req = 1'b1; if_addr = 32'h30;
      for (int c = 1; c <= TO + 2; c++) begin
         if (c == TO + 2) exp_err = 1'b1;
         cyc();
         if (c <= TO + 1) begin
            chk1("t6_valid", mem_valid, 1'b1);
            chk1("t6_no_done", if_done, 1'b0);
         end else begin
            chk1("t6_if_done", if_done, 1'b1);
            chk1("t6_valid_drop", mem_valid, 1'b0);
            chk("t6_if_rdata", if_rdata, 32'h00000013);
         end
      end
      if_req = 1'b0;
      exp_if_rdata = 32'h00000013;
      rdy_mode = 1; chk_timing = 1'b1;
      repeat (3) cyc();
      chk1("t6_err_sticky", mem_err, 1'b1);
      #3 Reset = 1'b1;
      #1;
      chk1("t6_err_cleared", mem_err, 1'b0);
      exp_err = 1'b0; exp_if_rdata = '0; exp_d_rdata = '0;
      @(posedge clock);
      #2 Reset = 1'b0;
      repeat (2) cyc();
`endif

      // Randomized operations with random wait states
      rdy_mode = 0;
      for (int k = 0; k < 40; k++) begin
         int          op;
         bit          f, rd, wr;
         logic [31:0] ia, da, wd;
         op = $urandom_range(0, 3);
         f  = (op == 0) || (op == 3);
         rd = (op == 1);
         wr = (op == 2);
         if (op == 3) begin
            case ($urandom_range(0, 2))
               0:       rd = 1'b1;
               1:       wr = 1'b1;
               default: begin rd = 1'b1; wr = 1'b1; end
            endcase
         end
         ia = $urandom & 32'hFFFF_FFFC;
         da = $urandom & 32'hFFFF_FFFC;
         wd = $urandom;
         do_op(f, rd, wr, ia, da, wd, ia_at, d_at);
      end
      chk1("final_mem_err", mem_err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
